// File: rtl/delay_timer.sv
// delay_timer
//   CHIP-8 delay timer. The CPU loads a down-counter through write_enable/data.
//   The counter then decrements once for every rising edge of the 60 Hz strobe
//   clk_60 until it reaches zero, and it stays at zero after that. clk_60 is
//   treated as an ordinary level signal that is sampled in the clk domain. It is
//   never used as a clock.
//
// Ports
//   clk           in   1      system clock; all state updates on its rising edge
//   reset         in   1      synchronous, active-high reset
//   clk_60        in   1      60 Hz tick strobe, sampled in the clk domain
//   write_enable  in   1      load strobe; data is loaded into the counter
//   data          in   WIDTH  load value
//   out           out  1      1 while the count is non-zero (timer running)
//   value         out  WIDTH  current count, read back by the CPU (FX07)

module delay_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_60,
   input  logic             write_enable,
   input  logic [WIDTH-1:0] data,
   output logic             out,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             clk60_q;
   logic             clk60_d;
   logic             tick;

   // A tick is the first cycle in which clk_60 is sampled high after it was
   // sampled low. Holding clk_60 high therefore produces exactly one tick.
   always_comb begin
      tick = clk_60 & ~clk60_q;
   end

   // Next-state logic. A load has priority over a tick. A tick that arrives
   // together with a load is dropped. The previous-sample register still
   // follows clk_60 during a load, so the edge cannot cause a decrement in a
   // later cycle. When the count is zero, a tick leaves it at zero instead of
   // letting it wrap around.
   always_comb begin
      count_d = count_q;
      clk60_d = clk_60;
      if (write_enable) begin
         count_d = data;
      end else if (tick && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // State registers. Reset is synchronous and overrides a load or a tick in
   // the same cycle. Clearing the sample register means that clk_60 must be
   // seen low after reset before it can produce a tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         clk60_q <= 1'b0;
      end else begin
         count_q <= count_d;
         clk60_q <= clk60_d;
      end
   end

   // The outputs are decoded directly from the count register, so they change
   // at the same clk edge as the count.
   always_comb begin
      out   = (count_q != '0);
      value = count_q;
   end

endmodule

// File: tb/tb_delay_timer.sv
// tb_delay_timer
//   Self-checking bench for delay_timer. A table of per-cycle vectors holds the
//   inputs and the expected outputs after that clock edge. Each vector is driven
//   on the falling edge, and its expectation is pushed to a scoreboard queue. A
//   monitor pops the queue one time unit after every rising edge and compares
//   the expectation with the DUT outputs.

module tb_delay_timer;

   localparam int WIDTH = 8;

   typedef struct {
      logic             rst;
      logic             c60;
      logic             we;
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] expValue;
      logic             expOut;
   } vec_t;

   typedef struct {
      int               idx;
      logic [WIDTH-1:0] expValue;
      logic             expOut;
   } exp_t;

   logic             clock;
   logic             reset;
   logic             clk60;
   logic             writeEnable;
   logic [WIDTH-1:0] dataIn;
   logic             outFlag;
   logic [WIDTH-1:0] valueOut;

   vec_t vecTable[$];
   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   delay_timer #(.WIDTH(WIDTH)) dut (
      .clk          (clock),
      .reset        (reset),
      .clk_60       (clk60),
      .write_enable (writeEnable),
      .data         (dataIn),
      .out          (outFlag),
      .value        (valueOut)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Append one cycle to the vector table.
   task automatic addVec(input logic r, input logic c, input logic w,
                         input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ev,
                         input logic eo);
      vec_t v;
      v.rst = r; v.c60 = c; v.we = w; v.data = d; v.expValue = ev; v.expOut = eo;
      vecTable.push_back(v);
   endtask

   // Drive one vector away from the rising edge and queue its expectation.
   task automatic applyStimulus(input int idx, input vec_t v);
      exp_t e;
      @(negedge clock);
      reset       = v.rst;
      clk60       = v.c60;
      writeEnable = v.we;
      dataIn      = v.data;
      e.idx = idx; e.expValue = v.expValue; e.expOut = v.expOut;
      expQ.push_back(e);
   endtask

   // Pop one expectation and compare it with the DUT outputs.
   task automatic checkOutput();
      exp_t e;
      e = expQ.pop_front();
      checks++;
      if (valueOut !== e.expValue) begin
         errors++;
         $display("[TB] FAIL vec%0d value: got %0d expected %0d", e.idx, valueOut, e.expValue);
      end
      checks++;
      if (outFlag !== e.expOut) begin
         errors++;
         $display("[TB] FAIL vec%0d out: got %0b expected %0b", e.idx, outFlag, e.expOut);
      end
   endtask

   always @(posedge clock) begin
      #1;
      if (expQ.size() > 0) checkOutput();
   end

   initial begin
      int waitCycles;
      int dec;
      reset = 1'b1; clk60 = 1'b0; writeEnable = 1'b0; dataIn = '0;

      // Reset held for two cycles while clk_60 toggles and a write of FF is requested.
      addVec(1, 1, 1, 8'hFF, 8'd0, 0);
      addVec(1, 0, 1, 8'hFF, 8'd0, 0);

      // Idle: clk_60 toggles every cycle while the count is zero, so it saturates at zero.
      for (int k = 0; k < 8; k++) addVec(0, (k % 2 == 0), 0, 8'h00, 8'd0, 0);

      // Load 8 with clk_60 high for two cycles. A toggling clk_60 then gives one decrement per two cycles.
      addVec(0, 1, 1, 8'd8, 8'd8, 1);
      addVec(0, 1, 1, 8'd8, 8'd8, 1);
      for (int k = 0; k < 64; k++) begin
         dec = (k + 1) / 2;
         if (dec > 8) dec = 8;
         addVec(0, (k % 2 == 1), 0, 8'h00, 8'(8 - dec), (8 - dec) != 0);
      end

      // Tick during write: the rising clk_60 is consumed by the load of 5, and a held level gives no extra tick.
      addVec(0, 0, 0, 8'h00, 8'd0, 0);
      addVec(0, 1, 1, 8'd5, 8'd5, 1);
      addVec(0, 1, 0, 8'h00, 8'd5, 1);
      addVec(0, 1, 0, 8'h00, 8'd5, 1);
      addVec(0, 1, 0, 8'h00, 8'd5, 1);
      addVec(0, 0, 0, 8'h00, 8'd5, 1);
      addVec(0, 1, 0, 8'h00, 8'd4, 1);

      // Reload at value 3 with 0x10. The countdown then resumes from 16.
      addVec(0, 0, 0, 8'h00, 8'd4, 1);
      addVec(0, 1, 0, 8'h00, 8'd3, 1);
      addVec(0, 0, 1, 8'h10, 8'd16, 1);
      addVec(0, 1, 0, 8'h00, 8'd15, 1);
      addVec(0, 0, 0, 8'h00, 8'd15, 1);
      addVec(0, 1, 0, 8'h00, 8'd14, 1);

      // Write zero at value 4: the timer stops at once and then saturates.
      addVec(0, 0, 1, 8'd6, 8'd6, 1);
      addVec(0, 1, 0, 8'h00, 8'd5, 1);
      addVec(0, 0, 0, 8'h00, 8'd5, 1);
      addVec(0, 1, 0, 8'h00, 8'd4, 1);
      addVec(0, 0, 1, 8'h00, 8'd0, 0);
      addVec(0, 1, 0, 8'h00, 8'd0, 0);

      // Reset at value 4 has priority over a write in the same cycle.
      addVec(0, 0, 1, 8'd5, 8'd5, 1);
      addVec(0, 1, 0, 8'h00, 8'd4, 1);
      addVec(1, 0, 1, 8'd9, 8'd0, 0);
      addVec(0, 1, 0, 8'h00, 8'd0, 0);

      // Holding write_enable reloads data every cycle, even while clk_60 toggles.
      addVec(0, 0, 1, 8'd3, 8'd3, 1);
      addVec(0, 1, 1, 8'd3, 8'd3, 1);
      addVec(0, 0, 1, 8'd7, 8'd7, 1);
      addVec(0, 1, 0, 8'h00, 8'd6, 1);

      // A load of all ones counts down fully to zero without wrapping.
      addVec(0, 0, 1, 8'hFF, 8'd255, 1);
      for (int k = 0; k < 510; k++) begin
         dec = k / 2 + 1;
         addVec(0, (k % 2 == 0), 0, 8'h00, 8'(255 - dec), (255 - dec) != 0);
      end
      addVec(0, 0, 0, 8'h00, 8'd0, 0);
      addVec(0, 1, 0, 8'h00, 8'd0, 0);

      $display("[TB] applying %0d vectors", vecTable.size());
      for (int i = 0; i < vecTable.size(); i++) applyStimulus(i, vecTable[i]);

      // Drain the scoreboard within a bounded number of cycles.
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clock);
         waitCycles++;
      end
      #2;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
